// File: rtl/lib_cmps_from_pow2_if.sv
// Beat-in / frame-out handshake bundle for the one-hot recomposer.
// The slave side is the recomposer; the master side feeds beats and takes results.
interface lib_cmps_from_pow2_if #(
   parameter int WIDTH = 16,
   parameter int CW    = 5
);
   logic [WIDTH-1:0] onehot_i;
   logic             vld_i;
   logic             last_i;
   logic             rdy_o;
   logic [WIDTH-1:0] vect_o;
   logic [CW-1:0]    cnt_o;
   logic [2:0]       err_o;
   logic             vld_o;
   logic             rdy_i;

   modport slave (
      input  onehot_i, vld_i, last_i, rdy_i,
      output rdy_o, vect_o, cnt_o, err_o, vld_o
   );

   modport master (
      output onehot_i, vld_i, last_i, rdy_i,
      input  rdy_o, vect_o, cnt_o, err_o, vld_o
   );
endinterface

// File: rtl/lib_cmps_from_pow2.sv
// Serial recomposer: ORs a frame of one-hot beats into a WIDTH-bit word,
// checking form, bit order and beat count, then hands the word off.
module lib_cmps_from_pow2 #(
   parameter int WIDTH   = 16,
   parameter int LSB_MSB = 0,
   parameter int CNT_MAX = WIDTH,
   parameter int CW      = $clog2(CNT_MAX + 1)
) (
   input logic                 clk,
   input logic                 rst,
   lib_cmps_from_pow2_if.slave bus
);

   typedef enum logic {ACC, HOLD} state_t;

   state_t           state, state_nxt;
   logic             rdy_q;
   logic [WIDTH-1:0] acc, acc_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [2:0]       err, err_nxt;

   logic             accept;
   logic             cnt_full;
   logic             multi_hot;
   logic [WIDTH-1:0] order_mask;

   assign accept    = bus.vld_i & rdy_q;
   assign cnt_full  = (cnt == CW'(CNT_MAX));
   assign multi_hot = (bus.onehot_i & (bus.onehot_i - WIDTH'(1))) != '0;
   // Mask of positions an already-set bit must not occupy for this beat to be in order.
   assign order_mask = (LSB_MSB == 0) ? ~(bus.onehot_i - WIDTH'(1))
                                      : ((bus.onehot_i << 1) - WIDTH'(1));

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      err_nxt   = err;
      case (state)
         ACC: begin
            if (accept) begin
               if (cnt_full) begin
                  err_nxt[2] = 1'b1;
               end else begin
                  cnt_nxt = cnt + CW'(1);
                  if (bus.onehot_i == '0) begin
                     // bypass beat: counted only
                  end else if (multi_hot) begin
                     err_nxt[0] = 1'b1;
                  end else begin
                     if ((acc & order_mask) != '0) err_nxt[1] = 1'b1;
                     acc_nxt = acc | bus.onehot_i;
                  end
               end
               if (bus.last_i) state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (bus.rdy_i) begin
               state_nxt = ACC;
               acc_nxt   = '0;
               cnt_nxt   = '0;
               err_nxt   = '0;
            end
         end
         default: state_nxt = ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ACC;
         rdy_q <= 1'b0;
         acc   <= '0;
         cnt   <= '0;
         err   <= '0;
      end else begin
         state <= state_nxt;
         rdy_q <= (state_nxt == ACC);
         acc   <= acc_nxt;
         cnt   <= cnt_nxt;
         err   <= err_nxt;
      end
   end

   assign bus.rdy_o  = rdy_q;
   assign bus.vld_o  = (state == HOLD);
   assign bus.vect_o = (state == HOLD) ? acc : '0;
   assign bus.cnt_o  = (state == HOLD) ? cnt : '0;
   assign bus.err_o  = (state == HOLD) ? err : '0;

endmodule

// File: tb/tb_lib_cmps_from_pow2.sv
// Directed bench: three recomposers (LSB-first, MSB-first, CNT_MAX=2) share one
// beat stream; each frame result is compared against hand-computed values.
module tb_lib_cmps_from_pow2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [15:0] onehot = '0;
   logic vld = 1'b0;
   logic last = 1'b0;
   logic rdy_i = 1'b0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lib_cmps_from_pow2_if #(.WIDTH(16), .CW(5)) b0 ();
   lib_cmps_from_pow2_if #(.WIDTH(16), .CW(5)) b1 ();
   lib_cmps_from_pow2_if #(.WIDTH(16), .CW(2)) b2 ();

   assign b0.onehot_i = onehot; assign b0.vld_i = vld; assign b0.last_i = last; assign b0.rdy_i = rdy_i;
   assign b1.onehot_i = onehot; assign b1.vld_i = vld; assign b1.last_i = last; assign b1.rdy_i = rdy_i;
   assign b2.onehot_i = onehot; assign b2.vld_i = vld; assign b2.last_i = last; assign b2.rdy_i = rdy_i;

   lib_cmps_from_pow2 #(.WIDTH(16), .LSB_MSB(0), .CNT_MAX(16)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
   lib_cmps_from_pow2 #(.WIDTH(16), .LSB_MSB(1), .CNT_MAX(16)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
   lib_cmps_from_pow2 #(.WIDTH(16), .LSB_MSB(0), .CNT_MAX(2))  u_dut2 (.clk(clk), .rst(rst), .bus(b2));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Snapshot of one DUT's outputs, selected by index.
   task automatic peek(input int d, output logic [31:0] vect, output logic [31:0] cnt,
                       output logic [31:0] err, output logic [31:0] v, output logic [31:0] r);
      case (d)
         0:       begin vect = 32'(b0.vect_o); cnt = 32'(b0.cnt_o); err = 32'(b0.err_o); v = 32'(b0.vld_o); r = 32'(b0.rdy_o); end
         1:       begin vect = 32'(b1.vect_o); cnt = 32'(b1.cnt_o); err = 32'(b1.err_o); v = 32'(b1.vld_o); r = 32'(b1.rdy_o); end
         default: begin vect = 32'(b2.vect_o); cnt = 32'(b2.cnt_o); err = 32'(b2.err_o); v = 32'(b2.vld_o); r = 32'(b2.rdy_o); end
      endcase
   endtask

   task automatic chk_res(input string tag, input int d, input logic [31:0] ev,
                          input logic [31:0] ec, input logic [31:0] ee);
      logic [31:0] vect, cnt, err, v, r;
      peek(d, vect, cnt, err, v, r);
      chk({tag, ".vld"}, v, 32'd1);
      chk({tag, ".rdy"}, r, 32'd0);
      chk({tag, ".vect"}, vect, ev);
      chk({tag, ".cnt"}, cnt, ec);
      chk({tag, ".err"}, err, ee);
   endtask

   task automatic beat(input logic [15:0] oh, input logic lst);
      @(negedge clk);
      onehot = oh; vld = 1'b1; last = lst;
      @(posedge clk);
      #1 vld = 1'b0; last = 1'b0; onehot = '0;
   endtask

   task automatic release_res(input string tag);
      logic [31:0] vect, cnt, err, v, r;
      @(negedge clk);
      rdy_i = 1'b1;
      @(posedge clk);
      #1 rdy_i = 1'b0;
      @(negedge clk);
      peek(0, vect, cnt, err, v, r);
      chk({tag, ".rel_vld"}, v, 32'd0);
      chk({tag, ".rel_rdy"}, r, 32'd1);
   endtask

   task automatic do_reset(input string tag);
      logic [31:0] vect, cnt, err, v, r;
      @(negedge clk);
      rst = 1'b1; vld = 1'b0; last = 1'b0; rdy_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      peek(0, vect, cnt, err, v, r);
      chk({tag, ".rst_vld"}, v, 32'd0);
      chk({tag, ".rst_rdy"}, r, 32'd0);
      chk({tag, ".rst_bus"}, vect | cnt | err, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      peek(0, vect, cnt, err, v, r);
      chk({tag, ".post_rdy"}, r, 32'd1);
   endtask

   initial begin
      logic [31:0] vect, cnt, err, v, r;
      logic [31:0] hv;

      do_reset("init");

      // In-order frame, plus a last_i pulse without vld_i that must be ignored.
      @(negedge clk); last = 1'b1;
      @(posedge clk); #1 last = 1'b0;
      @(negedge clk);
      peek(0, vect, cnt, err, v, r);
      chk("t1.last_no_vld", v, 32'd0);
      beat(16'h0001, 1'b0);
      beat(16'h0004, 1'b0);
      @(negedge clk);
      peek(0, vect, cnt, err, v, r);
      chk("t1.mid_vld", v, 32'd0);
      beat(16'h0100, 1'b1);
      @(negedge clk);
      chk_res("t1", 0, 32'h0105, 32'd3, 32'd0);
      release_res("t1");

      // Bypass beat in the middle.
      beat(16'h0010, 1'b0);
      beat(16'h0000, 1'b0);
      beat(16'h0080, 1'b1);
      @(negedge clk);
      chk_res("t2", 0, 32'h0090, 32'd3, 32'd0);
      release_res("t2");

      // Descending bit on LSB-first: order error.
      beat(16'h0040, 1'b0);
      beat(16'h0008, 1'b1);
      @(negedge clk);
      chk_res("t3", 0, 32'h0048, 32'd2, 32'b010);
      release_res("t3");

      // Duplicate bit: order error, acc unchanged.
      beat(16'h0040, 1'b0);
      beat(16'h0040, 1'b1);
      @(negedge clk);
      chk_res("t4", 0, 32'h0040, 32'd2, 32'b010);
      release_res("t4");

      // Multi-hot single-beat frame.
      beat(16'h0003, 1'b1);
      @(negedge clk);
      chk_res("t5", 0, 32'h0000, 32'd1, 32'b001);
      release_res("t5");

      // MSB-first ordering: clean on dut1, order error on dut0.
      do_reset("r6");
      beat(16'h8000, 1'b0);
      beat(16'h0002, 1'b1);
      @(negedge clk);
      chk_res("t6.msb", 1, 32'h8002, 32'd2, 32'd0);
      chk_res("t6.lsb", 0, 32'h8002, 32'd2, 32'b010);
      release_res("t6");

      // Beat overflow with CNT_MAX=2; last is still honoured.
      do_reset("r7");
      beat(16'h0001, 1'b0);
      beat(16'h0002, 1'b0);
      beat(16'h0004, 1'b1);
      @(negedge clk);
      chk_res("t7.cap2", 2, 32'h0003, 32'd2, 32'b100);
      chk_res("t7.cap16", 0, 32'h0007, 32'd3, 32'd0);
      release_res("t7");

      // Backpressure: result held, incoming beats ignored.
      beat(16'h0001, 1'b0);
      beat(16'h0002, 1'b1);
      @(negedge clk);
      chk_res("t8", 0, 32'h0003, 32'd2, 32'd0);
      onehot = 16'h8000; vld = 1'b1; last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk_res($sformatf("t8.bp%0d", i), 0, 32'h0003, 32'd2, 32'd0);
      end
      vld = 1'b0; last = 1'b0; onehot = '0;
      release_res("t8");
      beat(16'h0004, 1'b1);
      @(negedge clk);
      chk_res("t8.next", 0, 32'h0004, 32'd1, 32'd0);
      release_res("t8n");

      // Reset mid-frame discards partial frame.
      beat(16'h0001, 1'b0);
      beat(16'h0002, 1'b0);
      do_reset("r9");
      hv = 32'(b0.vld_o);
      chk("t9.no_vld", hv, 32'd0);
      beat(16'h0002, 1'b1);
      @(negedge clk);
      chk_res("t9", 0, 32'h0002, 32'd1, 32'd0);
      release_res("t9");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
